// File: rtl/x_serializer.sv
// x_serializer
// Parallel-to-serial feeder for a serial-input Mealy FSM. A word is accepted
// through a valid/ready handshake and shifted out one bit per clock on x_out.
// The next word can be accepted on the last-bit edge, so consecutive words
// form a continuous bit stream with no gap cycle.
//
// Parameters:
//   WIDTH      bits per word (>= 1)
//   LSB_FIRST  0: MSB shifted first, 1: LSB shifted first
//   IDLE_BIT   level driven on x_out while no word is being shifted
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   data_in     parallel word, sampled only on an accepting edge
//   load_valid  a word is offered on data_in
//   load_ready  a word offered now is taken at the next edge
//   x_out       serial data bit (registered)
//   x_valid     x_out carries a data bit (registered)
//   x_last      x_out carries the final bit of the current word
module x_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             x_last
);

    // The counter must be at least one bit wide even when WIDTH is 1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sh_r;
    logic [WIDTH-1:0] sh_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic             x_out_r;
    logic             x_out_nxt_s;
    logic             x_valid_r;
    logic             x_valid_nxt_s;
    logic             cnt_zero_s;
    logic             ready_s;
    logic             accept_s;

    // Bit sitting at the output end of a word.
    function automatic logic head_bit(input logic [WIDTH-1:0] word);
        head_bit = LSB_FIRST ? word[0] : word[WIDTH-1];
    endfunction

    // Move a word one place toward the output end.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
        advance = LSB_FIRST ? (word >> 1'b1) : (word << 1'b1);
    endfunction

    // Handshake and framing flags decoded from registered state only.
    always_comb begin
        cnt_zero_s = (cnt_r == {CW{1'b0}});
        ready_s    = !x_valid_r || cnt_zero_s;
        accept_s   = load_valid && ready_s;
    end

    // Next-state logic: load, shift, drain to idle, or hold while idle.
    always_comb begin
        sh_nxt_s      = sh_r;
        cnt_nxt_s     = cnt_r;
        x_out_nxt_s   = x_out_r;
        x_valid_nxt_s = x_valid_r;
        if (accept_s) begin
            // The first bit goes straight to x_out; the shift register keeps the rest.
            x_out_nxt_s   = head_bit(data_in);
            sh_nxt_s      = advance(data_in);
            cnt_nxt_s     = CW'(WIDTH - 1);
            x_valid_nxt_s = 1'b1;
        end else if (x_valid_r && !cnt_zero_s) begin
            x_out_nxt_s   = head_bit(sh_r);
            sh_nxt_s      = advance(sh_r);
            cnt_nxt_s     = cnt_r - CW'(1);
            x_valid_nxt_s = 1'b1;
        end else if (x_valid_r) begin
            // Last bit shown and no follow-on word: fall back to idle.
            x_out_nxt_s   = IDLE_BIT;
            x_valid_nxt_s = 1'b0;
        end else begin
            x_out_nxt_s   = IDLE_BIT;
            x_valid_nxt_s = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_r      <= {WIDTH{1'b0}};
            cnt_r     <= {CW{1'b0}};
            x_out_r   <= IDLE_BIT;
            x_valid_r <= 1'b0;
        end else begin
            sh_r      <= sh_nxt_s;
            cnt_r     <= cnt_nxt_s;
            x_out_r   <= x_out_nxt_s;
            x_valid_r <= x_valid_nxt_s;
        end
    end

    // Output mapping.
    always_comb begin
        x_out      = x_out_r;
        x_valid    = x_valid_r;
        load_ready = ready_s;
        x_last     = x_valid_r && cnt_zero_s;
    end

endmodule

// File: tb/tb_x_serializer.sv
// Testbench for x_serializer. Three instances: A (WIDTH=8, MSB first, idle 0),
// B (WIDTH=8, LSB first, idle 1) and C (WIDTH=1). A queue-based model predicts
// every output each cycle; literal expectations pin the serial sequences.
module tb_x_serializer;

    logic       clk;
    logic       reset;
    logic [2:0] lv;
    logic [7:0] dat [3];

    logic xo_a, xv_a, xl_a, lr_a;
    logic xo_b, xv_b, xl_b, lr_b;
    logic xo_c, xv_c, xl_c, lr_c;
    logic [2:0] xo_v, xv_v, xl_v, lr_v;
    logic [0:0] dat_c;

    assign xo_v  = {xo_c, xo_b, xo_a};
    assign xv_v  = {xv_c, xv_b, xv_a};
    assign xl_v  = {xl_c, xl_b, xl_a};
    assign lr_v  = {lr_c, lr_b, lr_a};
    assign dat_c = dat[2][0:0];

    x_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .reset(reset), .data_in(dat[0]), .load_valid(lv[0]),
        .load_ready(lr_a), .x_out(xo_a), .x_valid(xv_a), .x_last(xl_a));

    x_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .data_in(dat[1]), .load_valid(lv[1]),
        .load_ready(lr_b), .x_out(xo_b), .x_valid(xv_b), .x_last(xl_b));

    x_serializer #(.WIDTH(1), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_c (
        .clk(clk), .reset(reset), .data_in(dat_c), .load_valid(lv[2]),
        .load_ready(lr_c), .x_out(xo_c), .x_valid(xv_c), .x_last(xl_c));

    int checks = 0;
    int errors = 0;

    // Model configuration per instance.
    int w_m    [3] = '{8, 8, 1};
    bit lsb_m  [3] = '{1'b0, 1'b1, 1'b0};
    bit idle_m [3] = '{1'b0, 1'b1, 1'b0};

    // Model state: bits still to appear after the current one, and the current one.
    bit mq [3][$];
    bit cv [3];
    bit cb [3];
    bit cl [3];
    bit chk_en = 1'b0;

    // Recorders of the emitted stream.
    logic [15:0] rec   [3];
    int          rcnt  [3];
    int          nlast [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a word becomes a list of bits; one bit leaves per clock.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!reset) begin
                    mq[i].delete();
                    cv[i] = 1'b0;
                    cb[i] = idle_m[i];
                    cl[i] = 1'b0;
                end else begin
                    if (lv[i] && mq[i].size() == 0) begin
                        for (int j = 0; j < w_m[i]; j++)
                            mq[i].push_back(lsb_m[i] ? dat[i][j] : dat[i][w_m[i]-1-j]);
                    end
                    if (mq[i].size() > 0) begin
                        cb[i] = mq[i].pop_front();
                        cv[i] = 1'b1;
                        cl[i] = (mq[i].size() == 0);
                    end else begin
                        cv[i] = 1'b0;
                        cb[i] = idle_m[i];
                        cl[i] = 1'b0;
                    end
                end
            end
            chk_en = 1'b1;
        end
    end

    // Compare process: every output of every instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (xv_v[i] !== cv[i]) begin
                        errors++;
                        $display("FAIL x_valid[%0d] t=%0t got %b want %b", i, $time, xv_v[i], cv[i]);
                    end
                    checks++;
                    if (xo_v[i] !== cb[i]) begin
                        errors++;
                        $display("FAIL x_out[%0d] t=%0t got %b want %b", i, $time, xo_v[i], cb[i]);
                    end
                    checks++;
                    if (xl_v[i] !== (cv[i] && cl[i])) begin
                        errors++;
                        $display("FAIL x_last[%0d] t=%0t got %b want %b", i, $time, xl_v[i], cv[i] && cl[i]);
                    end
                    checks++;
                    if (lr_v[i] !== (mq[i].size() == 0)) begin
                        errors++;
                        $display("FAIL load_ready[%0d] t=%0t got %b want %b", i, $time, lr_v[i], mq[i].size() == 0);
                    end
                end
            end
        end
    end

    // Recorder of valid bits and last pulses.
    initial begin
        for (int i = 0; i < 3; i++) begin
            rec[i] = 16'h0000; rcnt[i] = 0; nlast[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (xv_v[i] === 1'b1) begin
                    rec[i]  = {rec[i][14:0], xo_v[i]};
                    rcnt[i] = rcnt[i] + 1;
                    if (xl_v[i] === 1'b1) nlast[i] = nlast[i] + 1;
                end
            end
        end
    end

    task automatic clr(input int i);
        rec[i] = 16'h0000; rcnt[i] = 0; nlast[i] = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lit(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    // Offer a word and hold it until an accepting edge (bounded).
    task automatic send(input int i, input logic [7:0] d);
        logic rdy;
        bit   done;
        done  = 1'b0;
        lv[i] = 1'b1;
        dat[i] = d;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            rdy = lr_v[i];
            @(posedge clk);
            #1;
            if (rdy === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout[%0d] got not accepted want accepted", i);
        end
    endtask

    initial begin
        logic [5:0] pat;
        pat    = 6'b101101;
        reset  = 1'b0;
        lv     = 3'b000;
        dat[0] = 8'h00; dat[1] = 8'h00; dat[2] = 8'h00;

        // 1: reset held with a word offered
        lv[0] = 1'b1; dat[0] = 8'hFF;
        tick(2);
        lit("rst_valid", int'(xv_v[0]), 0);
        lit("rst_xout", int'(xo_v[0]), 0);
        lit("rst_ready", int'(lr_v[0]), 1);
        lit("rst_last", int'(xl_v[0]), 0);
        lv[0] = 1'b0;
        reset = 1'b1;
        tick(1);

        // 2: single word MSB first
        clr(0);
        send(0, 8'hC1);
        lv[0] = 1'b0;
        tick(10);
        lit("single_bits", int'(rec[0]), 32'h00C1);
        lit("single_len", rcnt[0], 8);
        lit("single_last", nlast[0], 1);
        lit("single_idle", int'(xo_v[0]), 0);

        // 3: back-to-back words, no gap
        clr(0);
        send(0, 8'hC1);
        send(0, 8'h3C);
        lv[0] = 1'b0;
        tick(18);
        lit("b2b_bits", int'(rec[0]), 32'hC13C);
        lit("b2b_len", rcnt[0], 16);
        lit("b2b_last", nlast[0], 2);

        // 4: offer while busy is ignored
        clr(0);
        send(0, 8'hC1);
        lv[0] = 1'b0;
        tick(1);
        lv[0] = 1'b1; dat[0] = 8'hFF;
        tick(4);
        lv[0] = 1'b0;
        tick(8);
        lit("busy_bits", int'(rec[0]), 32'h00C1);
        lit("busy_len", rcnt[0], 8);

        // 5: reset in the middle of a word
        clr(0);
        send(0, 8'hC1);
        lv[0] = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        lit("midrst_valid", int'(xv_v[0]), 0);
        lit("midrst_xout", int'(xo_v[0]), 0);
        lit("midrst_ready", int'(lr_v[0]), 1);
        lit("midrst_len", rcnt[0], 4);
        reset = 1'b1;
        tick(1);
        clr(0);
        send(0, 8'h81);
        lv[0] = 1'b0;
        tick(10);
        lit("after_rst_bits", int'(rec[0]), 32'h0081);
        lit("after_rst_len", rcnt[0], 8);

        // 6a: LSB first, idle level 1
        clr(1);
        lit("lsb_idle_pre", int'(xo_v[1]), 1);
        send(1, 8'hC1);
        lv[1] = 1'b0;
        tick(10);
        lit("lsb_bits", int'(rec[1]), 32'h0083);
        lit("lsb_last", nlast[1], 1);
        lit("lsb_idle_post", int'(xo_v[1]), 1);

        // 6b: WIDTH=1 with continuous offers
        clr(2);
        lv[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            dat[2] = {7'b0000000, pat[5-k]};
            tick(1);
        end
        lv[2] = 1'b0;
        tick(3);
        lit("w1_bits", int'(rec[2]), 32'h002D);
        lit("w1_len", rcnt[2], 6);
        lit("w1_last", nlast[2], 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
